// File: rtl/sopc_data_bus.sv
// sopc_data_bus: data-side interconnect between the openmips data port and
// NUM_SLAVES memory-mapped slaves. addr[31:28] selects the slave; the access
// runs a req/ack handshake while the CPU is stalled. Unmapped regions and
// slaves that never acknowledge produce ERR_DATA and a one-cycle bus error.
//
// Optional build macro: SOPC_BUS_ERR_LOG_EN adds err_addr_o (address of the
// first error since reset, sticky) and err_cnt_o (saturating error count).
module sopc_data_bus #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  // CPU data port
  input  logic                    m_ce_i,
  input  logic                    m_we_i,
  input  logic [31:0]             m_addr_i,
  input  logic [3:0]              m_sel_i,
  input  logic [31:0]             m_data_i,
  output logic [31:0]             m_data_o,
  output logic                    m_stall_o,
  output logic                    bus_err_o,
  // slave side
  output logic [NUM_SLAVES-1:0]   s_req_o,
  output logic                    s_we_o,
  output logic [31:0]             s_addr_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_data_o,
  input  logic [32*NUM_SLAVES-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]   s_ack_i
`ifdef SOPC_BUS_ERR_LOG_EN
  ,
  output logic [31:0]             err_addr_o,
  output logic [7:0]              err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR,
    DONE
  } state_t;

  state_t                  state;
  logic [15:0]             tmo_cnt;
  logic                    err_flag;

  logic [3:0]              dec_idx;
  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    ack_hit;
  logic                    tmo_last;
  logic [31:0]             rd_data;

  assign dec_idx = m_addr_i[31:28];

  // Region index is 4 bits; widen by one so NUM_SLAVES==16 compares cleanly.
  assign dec_hit = ({1'b0, dec_idx} < 5'(NUM_SLAVES));

  assign tmo_last = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // One-hot request pattern for the slave addressed by the incoming access.
  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (dec_idx == 4'(i));
    end
  end

  // s_req_o is one-hot on the selected slave while in REQ, so masking the ack
  // vector with it discards acks from every other slave, and the same mask
  // steers the read-data mux without keeping a separate index register.
  always_comb begin
    ack_hit = |(s_ack_i & s_req_o);
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (s_req_o[i]) begin
        rd_data = rd_data | s_data_i[32*i +: 32];
      end
    end
  end

  // Stall the CPU for the whole access except the completion cycle.
  assign m_stall_o = rst & m_ce_i & (state != DONE);

  // The error pulse is exactly the DONE cycle of an errored access.
  assign bus_err_o = (state == DONE) & err_flag;

  // Transaction FSM: latch the CPU request, drive the slave handshake,
  // handle decode errors and timeouts, and return read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      s_req_o  <= '0;
      s_we_o   <= 1'b0;
      s_addr_o <= '0;
      s_sel_o  <= '0;
      s_data_o <= '0;
      m_data_o <= '0;
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_ce_i) begin
            s_we_o   <= m_we_i;
            s_addr_o <= m_addr_i;
            s_sel_o  <= m_sel_i;
            s_data_o <= m_data_i;
            tmo_cnt  <= '0;
            if (dec_hit) begin
              s_req_o <= req_onehot;
              state   <= REQ;
            end else begin
              state   <= ERR;
            end
          end
        end

        REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (ack_hit) begin
            // An ack in the final timeout cycle still completes normally.
            s_req_o <= '0;
            if (!s_we_o) begin
              m_data_o <= rd_data;
            end
            state <= DONE;
          end else if (tmo_last) begin
            s_req_o <= '0;
            state   <= ERR;
          end
        end

        ERR: begin
          s_req_o  <= '0;
          if (!s_we_o) begin
            m_data_o <= ERR_DATA;
          end
          err_flag <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          s_req_o  <= '0;
          tmo_cnt  <= '0;
          err_flag <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          s_req_o <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef SOPC_BUS_ERR_LOG_EN
  // Error log: capture the first failing address and count errors.
  // The counter saturates, so a zero count reliably means "no error yet".
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else if (state == ERR) begin
      if (err_cnt_o == 8'd0) begin
        err_addr_o <= s_addr_o;
      end
      if (err_cnt_o != 8'hFF) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed testbench for sopc_data_bus (NUM_SLAVES=4, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sopc_data_bus;

  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_ce_i;
  logic         m_we_i;
  logic [31:0]  m_addr_i;
  logic [3:0]   m_sel_i;
  logic [31:0]  m_data_i;
  logic [31:0]  m_data_o;
  logic         m_stall_o;
  logic         bus_err_o;
  logic [3:0]   s_req_o;
  logic         s_we_o;
  logic [31:0]  s_addr_o;
  logic [3:0]   s_sel_o;
  logic [31:0]  s_data_o;
  logic [127:0] s_data_i;
  logic [3:0]   s_ack_i;
`ifdef SOPC_BUS_ERR_LOG_EN
  logic [31:0]  err_addr_o;
  logic [7:0]   err_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  sopc_data_bus #(
    .NUM_SLAVES(4),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(ERRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_ce_i(m_ce_i),
    .m_we_i(m_we_i),
    .m_addr_i(m_addr_i),
    .m_sel_i(m_sel_i),
    .m_data_i(m_data_i),
    .m_data_o(m_data_o),
    .m_stall_o(m_stall_o),
    .bus_err_o(bus_err_o),
    .s_req_o(s_req_o),
    .s_we_o(s_we_o),
    .s_addr_o(s_addr_o),
    .s_sel_o(s_sel_o),
    .s_data_o(s_data_o),
    .s_data_i(s_data_i),
    .s_ack_i(s_ack_i)
`ifdef SOPC_BUS_ERR_LOG_EN
    ,
    .err_addr_o(err_addr_o),
    .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0;
    m_ce_i = 1'b1;
    m_addr_i = 32'h1000_0000;
    repeat (2) @(negedge clk);
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", m_stall_o); end
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL reset_req: got %b expected 0000", s_req_o); end
    checks++; if (s_we_o !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", s_we_o); end
    checks++; if (s_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", s_addr_o); end
    checks++; if (s_sel_o !== 4'h0) begin failures++; $display("FAIL reset_sel: got %h expected 0", s_sel_o); end
    checks++; if (s_data_o !== 32'h0) begin failures++; $display("FAIL reset_sdata: got %h expected 0", s_data_o); end
    checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL reset_mdata: got %h expected 0", m_data_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus_err_o); end
`ifdef SOPC_BUS_ERR_LOG_EN
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt_o); end
    checks++; if (err_addr_o !== 32'h0) begin failures++; $display("FAIL reset_erraddr: got %h expected 0", err_addr_o); end
`endif
    m_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_slave1();
    int stall_cnt;
    stall_cnt = 0;
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1000_0010; m_sel_i = 4'hF; m_data_i = 32'h0;
    #1 if (m_stall_o === 1'b1) stall_cnt++;
    @(negedge clk); // REQ cycle 1
    if (m_stall_o === 1'b1) stall_cnt++;
    checks++; if (s_req_o !== 4'b0010) begin failures++; $display("FAIL rd_req: got %b expected 0010", s_req_o); end
    checks++; if (s_addr_o !== 32'h1000_0010) begin failures++; $display("FAIL rd_addr: got %h expected 10000010", s_addr_o); end
    @(negedge clk); // REQ cycle 2
    if (m_stall_o === 1'b1) stall_cnt++;
    s_ack_i = 4'b0010; s_data_i[32 +: 32] = 32'hCAFE_0001;
    @(negedge clk); // DONE
    checks++; if (stall_cnt != 3) begin failures++; $display("FAIL rd_stall_cycles: got %0d expected 3", stall_cnt); end
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL rd_done_stall: got %b expected 0", m_stall_o); end
    checks++; if (m_data_o !== 32'hCAFE_0001) begin failures++; $display("FAIL rd_data: got %h expected cafe0001", m_data_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL rd_err: got %b expected 0", bus_err_o); end
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL rd_done_req: got %b expected 0000", s_req_o); end
    m_ce_i = 1'b0; s_ack_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_write_slave0();
    int stall_cnt;
    stall_cnt = 0;
    m_ce_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h0000_0004; m_sel_i = 4'b0011; m_data_i = 32'h1234_5678;
    #1 if (m_stall_o === 1'b1) stall_cnt++;
    @(negedge clk); // REQ cycle 1
    if (m_stall_o === 1'b1) stall_cnt++;
    checks++; if (s_req_o !== 4'b0001) begin failures++; $display("FAIL wr_req: got %b expected 0001", s_req_o); end
    checks++; if (s_we_o !== 1'b1) begin failures++; $display("FAIL wr_we: got %b expected 1", s_we_o); end
    checks++; if (s_sel_o !== 4'b0011) begin failures++; $display("FAIL wr_sel: got %b expected 0011", s_sel_o); end
    checks++; if (s_data_o !== 32'h1234_5678) begin failures++; $display("FAIL wr_sdata: got %h expected 12345678", s_data_o); end
    s_ack_i = 4'b0001; s_data_i[0 +: 32] = 32'hFFFF_FFFF;
    @(negedge clk); // DONE
    checks++; if (stall_cnt != 2) begin failures++; $display("FAIL wr_stall_cycles: got %0d expected 2", stall_cnt); end
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL wr_done_stall: got %b expected 0", m_stall_o); end
    checks++; if (m_data_o !== 32'hCAFE_0001) begin failures++; $display("FAIL wr_mdata_kept: got %h expected cafe0001", m_data_o); end
    m_ce_i = 1'b0; m_we_i = 1'b0; s_ack_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_decode_error();
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h5000_0000; m_sel_i = 4'hF;
    #1;
    checks++; if (m_stall_o !== 1'b1) begin failures++; $display("FAIL dec_stall_issue: got %b expected 1", m_stall_o); end
    @(negedge clk); // ERR
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL dec_req: got %b expected 0000", s_req_o); end
    checks++; if (m_stall_o !== 1'b1) begin failures++; $display("FAIL dec_stall_err: got %b expected 1", m_stall_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL dec_err_early: got %b expected 0", bus_err_o); end
    @(negedge clk); // DONE
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL dec_done_stall: got %b expected 0", m_stall_o); end
    checks++; if (bus_err_o !== 1'b1) begin failures++; $display("FAIL dec_err_pulse: got %b expected 1", bus_err_o); end
    checks++; if (m_data_o !== ERRD) begin failures++; $display("FAIL dec_data: got %h expected %h", m_data_o, ERRD); end
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL dec_req_done: got %b expected 0000", s_req_o); end
    m_ce_i = 1'b0;
    @(negedge clk); // IDLE
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL dec_err_single: got %b expected 0", bus_err_o); end
`ifdef SOPC_BUS_ERR_LOG_EN
    checks++; if (err_addr_o !== 32'h5000_0000) begin failures++; $display("FAIL dec_erraddr: got %h expected 50000000", err_addr_o); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL dec_errcnt: got %0d expected 1", err_cnt_o); end
`endif
  endtask

  task automatic test_timeout();
    int  req_cnt;
    bit  done;
    req_cnt = 0;
    done = 1'b0;
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h2000_0040; m_sel_i = 4'hF;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_stall_o === 1'b0) done = 1'b1;
      else if (s_req_o === 4'b0100) req_cnt++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL tmo_complete: got %b expected 1 (stall never released)", done); end
    checks++; if (req_cnt != 8) begin failures++; $display("FAIL tmo_req_cycles: got %0d expected 8", req_cnt); end
    checks++; if (bus_err_o !== 1'b1) begin failures++; $display("FAIL tmo_err_pulse: got %b expected 1", bus_err_o); end
    checks++; if (m_data_o !== ERRD) begin failures++; $display("FAIL tmo_data: got %h expected %h", m_data_o, ERRD); end
    m_ce_i = 1'b0;
    s_ack_i = 4'b0100; s_data_i[64 +: 32] = 32'h1111_1111;
    @(negedge clk); // IDLE, late ack present
    checks++; if (m_data_o !== ERRD) begin failures++; $display("FAIL tmo_late_ack: got %h expected %h", m_data_o, ERRD); end
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL tmo_req_after: got %b expected 0000", s_req_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL tmo_err_single: got %b expected 0", bus_err_o); end
    s_ack_i = 4'b0000;
    @(negedge clk);
`ifdef SOPC_BUS_ERR_LOG_EN
    checks++; if (err_cnt_o !== 8'd2) begin failures++; $display("FAIL tmo_errcnt: got %0d expected 2", err_cnt_o); end
    checks++; if (err_addr_o !== 32'h5000_0000) begin failures++; $display("FAIL tmo_erraddr_sticky: got %h expected 50000000", err_addr_o); end
`endif
  endtask

  task automatic test_ack_in_timeout_cycle();
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h2000_0080; m_sel_i = 4'hF;
    repeat (8) @(negedge clk); // now in REQ cycle 8, the last before timeout
    checks++; if (s_req_o !== 4'b0100) begin failures++; $display("FAIL lastack_req: got %b expected 0100", s_req_o); end
    s_ack_i = 4'b0100; s_data_i[64 +: 32] = 32'h7777_0002;
    @(negedge clk); // DONE
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL lastack_stall: got %b expected 0", m_stall_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL lastack_err: got %b expected 0", bus_err_o); end
    checks++; if (m_data_o !== 32'h7777_0002) begin failures++; $display("FAIL lastack_data: got %h expected 77770002", m_data_o); end
    m_ce_i = 1'b0; s_ack_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0020; m_sel_i = 4'hF;
    @(negedge clk); // REQ cycle 1
    s_ack_i = 4'b0001; s_data_i[0 +: 32] = 32'h1111_0000;
    @(negedge clk); // DONE of first access
    checks++; if (m_data_o !== 32'h1111_0000) begin failures++; $display("FAIL b2b_data1: got %h expected 11110000", m_data_o); end
    s_ack_i = 4'b0000; m_addr_i = 32'h1000_0030;
    @(negedge clk); // IDLE, second access issued
    checks++; if (m_stall_o !== 1'b1) begin failures++; $display("FAIL b2b_issue_stall: got %b expected 1", m_stall_o); end
    @(negedge clk); // REQ cycle 1 of second access
    checks++; if (s_req_o !== 4'b0010) begin failures++; $display("FAIL b2b_req2: got %b expected 0010", s_req_o); end
    checks++; if (s_addr_o !== 32'h1000_0030) begin failures++; $display("FAIL b2b_addr2: got %h expected 10000030", s_addr_o); end
    s_ack_i = 4'b0010; s_data_i[32 +: 32] = 32'h2222_0001;
    @(negedge clk); // DONE
    checks++; if (m_data_o !== 32'h2222_0001) begin failures++; $display("FAIL b2b_data2: got %h expected 22220001", m_data_o); end
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall2: got %b expected 0", m_stall_o); end
    m_ce_i = 1'b0; s_ack_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_stray_ack_reset();
    m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0100; m_sel_i = 4'hF;
    @(negedge clk); // REQ cycle 1
    checks++; if (s_req_o !== 4'b0001) begin failures++; $display("FAIL stray_req: got %b expected 0001", s_req_o); end
    s_ack_i = 4'b1000; s_data_i[96 +: 32] = 32'hBAD0_0003;
    @(negedge clk); // REQ cycle 2
    checks++; if (s_req_o !== 4'b0001) begin failures++; $display("FAIL stray_req_held: got %b expected 0001", s_req_o); end
    checks++; if (m_stall_o !== 1'b1) begin failures++; $display("FAIL stray_no_done: got %b expected 1", m_stall_o); end
    rst = 1'b0;
    @(negedge clk); // reset applied mid-REQ
    checks++; if (s_req_o !== 4'b0000) begin failures++; $display("FAIL rstmid_req: got %b expected 0000", s_req_o); end
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_stall: got %b expected 0", m_stall_o); end
    checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL rstmid_mdata: got %h expected 0", m_data_o); end
    rst = 1'b1; s_ack_i = 4'b0000; m_addr_i = 32'h3000_0008;
    #1;
    checks++; if (m_stall_o !== 1'b1) begin failures++; $display("FAIL post_rst_issue: got %b expected 1", m_stall_o); end
    @(negedge clk); // REQ cycle 1
    checks++; if (s_req_o !== 4'b1000) begin failures++; $display("FAIL post_rst_req: got %b expected 1000", s_req_o); end
    s_ack_i = 4'b1000; s_data_i[96 +: 32] = 32'hA5A5_0003;
    @(negedge clk); // DONE
    checks++; if (m_stall_o !== 1'b0) begin failures++; $display("FAIL post_rst_stall: got %b expected 0", m_stall_o); end
    checks++; if (m_data_o !== 32'hA5A5_0003) begin failures++; $display("FAIL post_rst_data: got %h expected a5a50003", m_data_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL post_rst_err: got %b expected 0", bus_err_o); end
    m_ce_i = 1'b0; s_ack_i = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    m_ce_i = 1'b0;
    m_we_i = 1'b0;
    m_addr_i = '0;
    m_sel_i = '0;
    m_data_i = '0;
    s_data_i = '0;
    s_ack_i = '0;
    test_reset();
    test_read_slave1();
    test_write_slave0();
    test_decode_error();
    test_timeout();
    test_ack_in_timeout_cycle();
    test_back_to_back();
    test_stray_ack_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
